// File: rtl/risc_toy_pkg.sv
// Shared RISC_TOY definitions: datapath widths, fetch FSM encoding, default reset PC.
package risc_toy_pkg;

  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 30;

  localparam logic [ADDR_W-1:0] DEFAULT_RESET_PC = 30'h0000_0000;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STALL = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry holding register that parks a fetch response while decode is stalled.
module fetch_skid_buf
  import risc_toy_pkg::*;
(
  input  logic               CLK,
  input  logic               RSTN,
  input  logic               load,
  input  logic               clear,
  input  logic [INSTR_W-1:0] load_instr,
  input  logic [ADDR_W-1:0]  load_pc,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  pc,
  output logic               valid
);

  logic [INSTR_W-1:0] instr_r;
  logic [ADDR_W-1:0]  pc_r;
  logic               valid_r;

  // Entry storage; a flush beats a simultaneous load.
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      instr_r <= 32'h0000_0000;
      pc_r    <= 30'h0000_0000;
      valid_r <= 1'b0;
    end else if (clear) begin
      valid_r <= 1'b0;
    end else if (load) begin
      instr_r <= load_instr;
      pc_r    <= load_pc;
      valid_r <= 1'b1;
    end else begin
      valid_r <= valid_r;
    end
  end

  assign instr = instr_r;
  assign pc    = pc_r;
  assign valid = valid_r;

endmodule

// File: rtl/risc_toy_fetch.sv
// RISC_TOY instruction fetch: PC, single outstanding memory request, IF/ID register,
// stall handling through a one-entry skid buffer and redirect flush.
module risc_toy_fetch
  import risc_toy_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic               CLK,
  input  logic               RSTN,
  output logic               IREQ,
  output logic [ADDR_W-1:0]  IADDR,
  input  logic [INSTR_W-1:0] INSTR,
  input  logic               ID_STALL,
  input  logic               REDIR_VALID,
  input  logic [ADDR_W-1:0]  REDIR_PC,
  output logic               ID_VALID,
  output logic [INSTR_W-1:0] ID_INSTR,
  output logic [ADDR_W-1:0]  ID_PC
);

  fetch_state_e       state_r;
  logic [ADDR_W-1:0]  pc_r;
  logic               pend_r;
  logic [ADDR_W-1:0]  pend_pc_r;
  logic               id_valid_r;
  logic [INSTR_W-1:0] id_instr_r;
  logic [ADDR_W-1:0]  id_pc_r;

  logic               ireq_s;
  logic               skid_load_s;
  logic               skid_clear_s;
  logic [INSTR_W-1:0] skid_instr_s;
  logic [ADDR_W-1:0]  skid_pc_s;
  logic               skid_valid_s;

  // Request and skid control; a redirect or stall suppresses the request that cycle.
  always_comb begin
    ireq_s       = 1'b0;
    skid_load_s  = 1'b0;
    skid_clear_s = 1'b0;
    if (RSTN && (state_r == ST_RUN || state_r == ST_STALL) && !ID_STALL && !REDIR_VALID) begin
      ireq_s = 1'b1;
    end else begin
      ireq_s = 1'b0;
    end
    if (REDIR_VALID || (!ID_STALL && skid_valid_s)) begin
      skid_clear_s = 1'b1;
    end else begin
      skid_load_s = ID_STALL & pend_r;
    end
  end

  fetch_skid_buf u_skid (
    .CLK        (CLK),
    .RSTN       (RSTN),
    .load       (skid_load_s),
    .clear      (skid_clear_s),
    .load_instr (INSTR),
    .load_pc    (pend_pc_r),
    .instr      (skid_instr_s),
    .pc         (skid_pc_s),
    .valid      (skid_valid_s)
  );

  // PC, response tracking, FSM and IF/ID register.
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state_r    <= ST_BOOT;
      pc_r       <= RESET_PC;
      pend_r     <= 1'b0;
      pend_pc_r  <= 30'h0000_0000;
      id_valid_r <= 1'b0;
      id_instr_r <= 32'h0000_0000;
      id_pc_r    <= 30'h0000_0000;
    end else begin
      pend_r    <= ireq_s;
      pend_pc_r <= pc_r;
      if (REDIR_VALID) begin
        // Any response arriving this cycle belongs to the wrong path and is dropped.
        pc_r       <= REDIR_PC;
        state_r    <= ST_RUN;
        id_valid_r <= 1'b0;
      end else begin
        if (ireq_s) begin
          pc_r <= pc_r + 30'd1;
        end else begin
          pc_r <= pc_r;
        end
        case (state_r)
          ST_BOOT:  state_r <= ST_RUN;
          ST_RUN:   state_r <= ID_STALL ? ST_STALL : ST_RUN;
          ST_STALL: state_r <= ID_STALL ? ST_STALL : ST_RUN;
          default:  state_r <= ST_BOOT;
        endcase
        if (!ID_STALL) begin
          if (skid_valid_s) begin
            id_valid_r <= 1'b1;
            id_instr_r <= skid_instr_s;
            id_pc_r    <= skid_pc_s;
          end else if (pend_r) begin
            id_valid_r <= 1'b1;
            id_instr_r <= INSTR;
            id_pc_r    <= pend_pc_r;
          end else begin
            id_valid_r <= 1'b0;
          end
        end else begin
          id_valid_r <= id_valid_r;
        end
      end
    end
  end

  assign IREQ     = ireq_s;
  assign IADDR    = pc_r;
  assign ID_VALID = id_valid_r;
  assign ID_INSTR = id_instr_r;
  assign ID_PC    = id_pc_r;

endmodule

// File: tb/tb_risc_toy_fetch.sv
// Self-checking bench for risc_toy_fetch: cycle table plus hand-written stall/redirect/wrap/reset
// sequences, with an in-order scoreboard of expected instruction addresses.
module tb_risc_toy_fetch;

  logic        CLK;
  logic        RSTN;
  logic        IREQ;
  logic [29:0] IADDR;
  logic [31:0] INSTR;
  logic        ID_STALL;
  logic        REDIR_VALID;
  logic [29:0] REDIR_PC;
  logic        ID_VALID;
  logic [31:0] ID_INSTR;
  logic [29:0] ID_PC;

  int n_checks = 0;
  int n_fail   = 0;
  logic [29:0] exp_q[$];

  risc_toy_fetch #(.RESET_PC(30'h0000_0000)) dut (
    .CLK(CLK), .RSTN(RSTN), .IREQ(IREQ), .IADDR(IADDR), .INSTR(INSTR),
    .ID_STALL(ID_STALL), .REDIR_VALID(REDIR_VALID), .REDIR_PC(REDIR_PC),
    .ID_VALID(ID_VALID), .ID_INSTR(ID_INSTR), .ID_PC(ID_PC)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Memory: data for the requested word appears the cycle after IREQ, junk otherwise.
  always @(posedge CLK) begin
    if (IREQ) INSTR <= 32'hA000_0000 + {2'b00, IADDR};
    else      INSTR <= 32'hDEAD_BEEF;
  end

  typedef struct packed {
    logic        st;
    logic        rd;
    logic [29:0] rpc;
    logic        ireq;
    logic [29:0] iaddr;
    logic        vld;
    logic [29:0] pc;
  } vec_t;

  vec_t tbl [20];

  function automatic vec_t mk(input logic st, input logic rd, input logic [29:0] rpc,
                              input logic ireq, input logic [29:0] iaddr,
                              input logic vld, input logic [29:0] pc);
    vec_t v;
    v.st = st; v.rd = rd; v.rpc = rpc; v.ireq = ireq; v.iaddr = iaddr; v.vld = vld; v.pc = pc;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic restart(input logic [29:0] start);
    logic [29:0] p;
    p = start;
    exp_q.delete();
    for (int i = 0; i < 40; i++) begin
      exp_q.push_back(p);
      p = p + 30'd1;
    end
  endtask

  // One cycle: drive inputs after the falling edge, then score the presented instruction.
  task automatic step(input logic st, input logic rd, input logic [29:0] rpc, input logic rn);
    @(negedge CLK);
    ID_STALL = st; REDIR_VALID = rd; REDIR_PC = rpc; RSTN = rn;
    #1;
    if (ID_VALID) begin
      if (exp_q.size() == 0) begin
        chk("sb_empty", 32'd1, 32'd0);
      end else begin
        chk("sb_pc", {2'b00, ID_PC}, {2'b00, exp_q[0]});
        chk("sb_instr", ID_INSTR, 32'hA000_0000 + {2'b00, exp_q[0]});
        if (rn && !st) void'(exp_q.pop_front());
      end
    end
    if (!rn) restart(30'h0000_0000);
    else if (rd) restart(rpc);
  endtask

  task automatic expect_out(input string tag, input logic ireq, input logic [29:0] iaddr,
                            input logic vld);
    chk({tag, "_ireq"}, {31'd0, IREQ}, {31'd0, ireq});
    chk({tag, "_iaddr"}, {2'b00, IADDR}, {2'b00, iaddr});
    chk({tag, "_vld"}, {31'd0, ID_VALID}, {31'd0, vld});
  endtask

  initial begin
    tbl[0]  = mk(1'b0, 1'b0, 30'h0,   1'b0, 30'h0,   1'b0, 30'h0);
    tbl[1]  = mk(1'b0, 1'b0, 30'h0,   1'b1, 30'h0,   1'b0, 30'h0);
    tbl[2]  = mk(1'b0, 1'b0, 30'h0,   1'b1, 30'h1,   1'b0, 30'h0);
    tbl[3]  = mk(1'b0, 1'b0, 30'h0,   1'b1, 30'h2,   1'b1, 30'h0);
    tbl[4]  = mk(1'b0, 1'b0, 30'h0,   1'b1, 30'h3,   1'b1, 30'h1);
    tbl[5]  = mk(1'b0, 1'b0, 30'h0,   1'b1, 30'h4,   1'b1, 30'h2);
    tbl[6]  = mk(1'b0, 1'b0, 30'h0,   1'b1, 30'h5,   1'b1, 30'h3);
    tbl[7]  = mk(1'b0, 1'b0, 30'h0,   1'b1, 30'h6,   1'b1, 30'h4);
    tbl[8]  = mk(1'b1, 1'b0, 30'h0,   1'b0, 30'h7,   1'b1, 30'h5);
    tbl[9]  = mk(1'b1, 1'b0, 30'h0,   1'b0, 30'h7,   1'b1, 30'h5);
    tbl[10] = mk(1'b1, 1'b0, 30'h0,   1'b0, 30'h7,   1'b1, 30'h5);
    tbl[11] = mk(1'b0, 1'b0, 30'h0,   1'b1, 30'h7,   1'b1, 30'h5);
    tbl[12] = mk(1'b0, 1'b0, 30'h0,   1'b1, 30'h8,   1'b1, 30'h6);
    tbl[13] = mk(1'b0, 1'b0, 30'h0,   1'b1, 30'h9,   1'b1, 30'h7);
    tbl[14] = mk(1'b0, 1'b0, 30'h0,   1'b1, 30'hA,   1'b1, 30'h8);
    tbl[15] = mk(1'b0, 1'b1, 30'h100, 1'b0, 30'hB,   1'b1, 30'h9);
    tbl[16] = mk(1'b0, 1'b0, 30'h0,   1'b1, 30'h100, 1'b0, 30'h0);
    tbl[17] = mk(1'b0, 1'b0, 30'h0,   1'b1, 30'h101, 1'b0, 30'h0);
    tbl[18] = mk(1'b0, 1'b0, 30'h0,   1'b1, 30'h102, 1'b1, 30'h100);
    tbl[19] = mk(1'b0, 1'b0, 30'h0,   1'b1, 30'h103, 1'b1, 30'h101);

    RSTN = 1'b0; ID_STALL = 1'b0; REDIR_VALID = 1'b0; REDIR_PC = 30'h0;
    repeat (3) @(negedge CLK);
    #1;
    expect_out("rst", 1'b0, 30'h0, 1'b0);
    chk("rst_instr", ID_INSTR, 32'h0000_0000);
    chk("rst_pc", {2'b00, ID_PC}, 32'h0000_0000);
    restart(30'h0000_0000);

    // Reset release, steady run, 3-cycle stall at ID_PC=5, redirect to 0x100 at ID_PC=9.
    for (int i = 0; i < 20; i++) begin
      step(tbl[i].st, tbl[i].rd, tbl[i].rpc, 1'b1);
      expect_out($sformatf("tbl%0d", i), tbl[i].ireq, tbl[i].iaddr, tbl[i].vld);
      if (tbl[i].vld) begin
        chk($sformatf("tbl%0d_pc", i), {2'b00, ID_PC}, {2'b00, tbl[i].pc});
        chk($sformatf("tbl%0d_instr", i), ID_INSTR, 32'hA000_0000 + {2'b00, tbl[i].pc});
      end
    end

    // Redirect and stall together: redirect wins and the parked skid entry is dropped.
    step(1'b1, 1'b0, 30'h0, 1'b1);
    expect_out("a1", 1'b0, 30'h104, 1'b1);
    step(1'b1, 1'b1, 30'h200, 1'b1);
    chk("a2_ireq", {31'd0, IREQ}, 32'd0);
    step(1'b0, 1'b0, 30'h0, 1'b1);
    expect_out("a3", 1'b1, 30'h200, 1'b0);
    step(1'b0, 1'b0, 30'h0, 1'b1);
    expect_out("a4", 1'b1, 30'h201, 1'b0);
    step(1'b0, 1'b0, 30'h0, 1'b1);
    expect_out("a5", 1'b1, 30'h202, 1'b1);
    chk("a5_pc", {2'b00, ID_PC}, 32'h0000_0200);

    // Address wrap at the top of the 30-bit space.
    step(1'b0, 1'b1, 30'h3FFF_FFFE, 1'b1);
    step(1'b0, 1'b0, 30'h0, 1'b1);
    expect_out("b1", 1'b1, 30'h3FFF_FFFE, 1'b0);
    step(1'b0, 1'b0, 30'h0, 1'b1);
    expect_out("b2", 1'b1, 30'h3FFF_FFFF, 1'b0);
    step(1'b0, 1'b0, 30'h0, 1'b1);
    expect_out("b3", 1'b1, 30'h0, 1'b1);
    chk("b3_pc", {2'b00, ID_PC}, 32'h3FFF_FFFE);
    step(1'b0, 1'b0, 30'h0, 1'b1);
    expect_out("b4", 1'b1, 30'h1, 1'b1);
    chk("b4_pc", {2'b00, ID_PC}, 32'h3FFF_FFFF);
    step(1'b0, 1'b0, 30'h0, 1'b1);
    expect_out("b5", 1'b1, 30'h2, 1'b1);
    chk("b5_pc", {2'b00, ID_PC}, 32'h0000_0000);

    // One-cycle reset while stalled with a parked skid entry.
    step(1'b1, 1'b0, 30'h0, 1'b1);
    chk("c1_ireq", {31'd0, IREQ}, 32'd0);
    step(1'b1, 1'b0, 30'h0, 1'b0);
    chk("c2_ireq", {31'd0, IREQ}, 32'd0);
    step(1'b0, 1'b0, 30'h0, 1'b1);
    expect_out("c3", 1'b0, 30'h0, 1'b0);
    chk("c3_instr", ID_INSTR, 32'h0000_0000);
    chk("c3_pc", {2'b00, ID_PC}, 32'h0000_0000);
    step(1'b0, 1'b0, 30'h0, 1'b1);
    expect_out("c4", 1'b1, 30'h0, 1'b0);
    step(1'b0, 1'b0, 30'h0, 1'b1);
    expect_out("c5", 1'b1, 30'h1, 1'b0);
    step(1'b0, 1'b0, 30'h0, 1'b1);
    expect_out("c6", 1'b1, 30'h2, 1'b1);
    chk("c6_pc", {2'b00, ID_PC}, 32'h0000_0000);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 30'h0, 1'b1);
    chk("c_final_pc", {2'b00, ID_PC}, 32'h0000_0004);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
